bcd_counter_chain: RTL and testbench
====================================

Name: bcd_counter_chain

Overview:
Parametrised cascaded BCD counter. Replaces the fixed three-digit up-counter with NUM_DIGITS digits, up/down counting, parallel load and a terminal-count output for cascading further chains. It is used for decimal event counters and timers feeding display drivers.

Parameters:
NUM_DIGITS, 3, number of BCD digits (1..8); digit 0 is least significant.
RESET_VALUE, 0, packed BCD value loaded on reset and clear (width 4*NUM_DIGITS); every nibble must be <= 9.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; forces qout to RESET_VALUE
clear  input  1  synchronous clear to RESET_VALUE
enable  input  1  count enable; one step per clk when high
up_dn  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load
load_val  input  4*NUM_DIGITS  packed BCD load value; digit i at [4i+3:4i]
qout  output  4*NUM_DIGITS  packed BCD count; digit i at [4i+3:4i]
cout  output  1  terminal count, combinational: enable & (qout at terminal for current up_dn)

Behaviour:
- Reset (async, active-high): qout = RESET_VALUE immediately. cout follows from qout/enable/up_dn and is never registered.
- Priority at each rising clk edge: reset > clear > load > enable > hold.
- clear=1: qout <= RESET_VALUE. load, enable and up_dn are ignored.
- load=1 (clear=0): qout <= load_val, digit-wise. Any nibble > 9 is clamped to 9. enable is ignored that cycle.
- enable=1, up_dn=1:
  - Digit 0 increments.
  - Digit i increments only when enable=1 and all lower digits == 9.
  - A digit at 9 that increments wraps to 0.
  - 99..9 -> 00..0 (full wrap).
- enable=1, up_dn=0:
  - Digit 0 decrements.
  - Digit i decrements only when all lower digits == 0.
  - A digit at 0 that decrements wraps to 9.
  - 00..0 -> 99..9.
- enable=0: hold.
- cout:
  - High when enable=1 and either up_dn=1 with all digits == 9, or up_dn=0 with all digits == 0.
  - Chains cascade by wiring cout into the next chain's enable.
- Latency: a count or load is visible on qout one cycle after the edge. cout responds combinationally to enable and up_dn changes within the same cycle.
- up_dn may change any cycle; the new direction applies at the next edge with no dead cycle.
- Non-BCD state never appears on qout in operation. Only a non-BCD RESET_VALUE, which is illegal, could produce it.
- Reset asserted mid-count: immediate return to RESET_VALUE. Counting resumes on the first edge after reset deasserts, if enable=1.

Optional Feature:
COUNT_SATURATE_EN
- Defined:
  - Counting up at 99..9 holds 99..9; counting down at 00..0 holds 00..0.
  - cout still asserts at the terminal value and stays high while enable=1 and the count is held there.
  - clear and load are unaffected.
- Undefined: wrap-around as described in Behaviour.

Test Plan:
- NUM_DIGITS=3. reset=1 for 20 ns, then released with clear=0, enable=1, up_dn=1 for 12 clks -> qout 000,001,...,012. The 009->010 step is correct; cout stays 0.
- load=1 with load_val=0x998, then enable=1, up_dn=1 -> 998, 999 (cout=1 during that cycle), then 000 (cout=0).
- load 0x100, then up_dn=0, enable=1 -> 099, 098. Load 0x000 with up_dn=0 -> cout=1; next edge gives 999.
- enable=1 while counting, then clear=1 and load=1 on the same edge -> qout=000. With clear=0, load=1, load_val=0xA5F -> qout=959 (clamped).
- Reset asserted asynchronously mid-cycle at qout=047 -> qout=000 before the next clk edge. enable=0 for 5 clks -> qout holds.
- COUNT_SATURATE_EN defined: at 999 with up_dn=1, enable=1 for 3 clks -> qout stays 999 and cout stays 1. At 000 with up_dn=0 -> stays 000.

Source files
------------

// File: rtl/bcd_counter_chain.sv
// Cascaded NUM_DIGITS BCD up/down counter with clamped parallel load; COUNT_SATURATE_EN makes terminal counts hold instead of wrapping.
// Latency: one cycle to qout, cout combinational from qout/enable/up_dn; no backpressure (enable is the only flow control).
module bcd_counter_chain #(
    parameter int                      NUM_DIGITS  = 3,
    parameter logic [4*NUM_DIGITS-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] qout,
    output logic                    cout
);

    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0] count_q;
    logic [W-1:0] count_nxt;
    logic [W-1:0] load_bcd;
    logic         all_nine;
    logic         all_zero;
    logic         terminal;
    logic         carry;
    logic [3:0]   dig;
    logic [3:0]   ld_dig;

    always_comb begin
        all_nine  = 1'b1;
        all_zero  = 1'b1;
        carry     = 1'b1;
        dig       = 4'd0;
        ld_dig    = 4'd0;
        count_nxt = count_q;
        load_bcd  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (dig != 4'd9) all_nine = 1'b0;
            if (dig != 4'd0) all_zero = 1'b0;
            // carry means every lower digit sits at its wrap boundary for the current direction
            if (carry) begin
                if (up_dn) count_nxt[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                else       count_nxt[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
            carry = carry & (up_dn ? (dig == 4'd9) : (dig == 4'd0));

            ld_dig = load_val[4*i +: 4];
            load_bcd[4*i +: 4] = (ld_dig > 4'd9) ? 4'd9 : ld_dig;
        end
        terminal = up_dn ? all_nine : all_zero;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VALUE;
        end else if (clear) begin
            count_q <= RESET_VALUE;
        end else if (load) begin
            count_q <= load_bcd;
        end else if (enable) begin
`ifdef COUNT_SATURATE_EN
            if (!terminal) count_q <= count_nxt;
`else
            count_q <= count_nxt;
`endif
        end
    end

    assign qout = count_q;
    assign cout = enable & terminal;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed bench for bcd_counter_chain (3 digits): counting, wrap, load clamp, priorities, async reset, saturation.
`timescale 1ns/1ps
module tb_bcd_counter_chain;

    logic        clk = 1'b0;
    logic        reset, clear, enable, up_dn, load;
    logic [11:0] load_val;
    logic [11:0] qout;
    logic        cout;

    int vectors = 0;
    int miscompares = 0;

    bcd_counter_chain #(.NUM_DIGITS(3), .RESET_VALUE(12'h000)) dut (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable), .up_dn(up_dn),
        .load(load), .load_val(load_val), .qout(qout), .cout(cout)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task test_reset;
        reset = 1'b1; clear = 1'b0; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        @(negedge clk); #2;
        vectors++;
        if (qout !== 12'h000) begin miscompares++; $display("FAIL reset_qout: got %h want 000", qout); end
        vectors++;
        if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b want 0", cout); end
        @(negedge clk);
        reset = 1'b0; enable = 1'b1; up_dn = 1'b1;
    endtask

    task test_count_up;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            vectors++;
            if (qout !== to_bcd(k)) begin miscompares++; $display("FAIL count_up[%0d]: got %h want %h", k, qout, to_bcd(k)); end
            vectors++;
            if (cout !== 1'b0) begin miscompares++; $display("FAIL count_up_cout[%0d]: got %b want 0", k, cout); end
        end
    endtask

    task test_wrap_up;
        load = 1'b1; load_val = 12'h998; enable = 1'b1; up_dn = 1'b1;
        @(negedge clk);
        load = 1'b0;
        vectors++;
        if (qout !== 12'h998 || cout !== 1'b0) begin miscompares++; $display("FAIL wrap_998: got %h/%b want 998/0", qout, cout); end
        @(negedge clk);
        vectors++;
        if (qout !== 12'h999 || cout !== 1'b1) begin miscompares++; $display("FAIL wrap_999: got %h/%b want 999/1", qout, cout); end
        @(negedge clk);
`ifdef COUNT_SATURATE_EN
        vectors++;
        if (qout !== 12'h999 || cout !== 1'b1) begin miscompares++; $display("FAIL wrap_hold: got %h/%b want 999/1", qout, cout); end
`else
        vectors++;
        if (qout !== 12'h000 || cout !== 1'b0) begin miscompares++; $display("FAIL wrap_000: got %h/%b want 000/0", qout, cout); end
`endif
    endtask

    task test_count_down;
        load = 1'b1; load_val = 12'h100; enable = 1'b1; up_dn = 1'b0;
        @(negedge clk);
        load = 1'b0;
        vectors++;
        if (qout !== 12'h100) begin miscompares++; $display("FAIL down_load: got %h want 100", qout); end
        @(negedge clk);
        vectors++;
        if (qout !== 12'h099) begin miscompares++; $display("FAIL down_099: got %h want 099", qout); end
        @(negedge clk);
        vectors++;
        if (qout !== 12'h098) begin miscompares++; $display("FAIL down_098: got %h want 098", qout); end
        load = 1'b1; load_val = 12'h000;
        @(negedge clk);
        load = 1'b0;
        vectors++;
        if (qout !== 12'h000 || cout !== 1'b1) begin miscompares++; $display("FAIL down_zero: got %h/%b want 000/1", qout, cout); end
        @(negedge clk);
`ifdef COUNT_SATURATE_EN
        vectors++;
        if (qout !== 12'h000 || cout !== 1'b1) begin miscompares++; $display("FAIL down_hold: got %h/%b want 000/1", qout, cout); end
`else
        vectors++;
        if (qout !== 12'h999 || cout !== 1'b0) begin miscompares++; $display("FAIL down_wrap: got %h/%b want 999/0", qout, cout); end
`endif
    endtask

    task test_clear_load;
        load = 1'b1; load_val = 12'h321; up_dn = 1'b1; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        vectors++;
        if (qout !== 12'h322) begin miscompares++; $display("FAIL pre_clear: got %h want 322", qout); end
        clear = 1'b1; load = 1'b1; load_val = 12'h555;
        @(negedge clk);
        vectors++;
        if (qout !== 12'h000) begin miscompares++; $display("FAIL clear_prio: got %h want 000", qout); end
        clear = 1'b0; load = 1'b1; load_val = 12'hA5F;
        @(negedge clk);
        load = 1'b0; enable = 1'b0;
        vectors++;
        if (qout !== 12'h959) begin miscompares++; $display("FAIL load_clamp: got %h want 959", qout); end
    endtask

    task test_direction_switch;
        load = 1'b1; load_val = 12'h047; enable = 1'b1; up_dn = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        vectors++;
        if (qout !== 12'h048) begin miscompares++; $display("FAIL dir_up: got %h want 048", qout); end
        up_dn = 1'b0;
        @(negedge clk);
        vectors++;
        if (qout !== 12'h047) begin miscompares++; $display("FAIL dir_down: got %h want 047", qout); end
        enable = 1'b0;
    endtask

    task test_async_reset_hold;
        // qout is 047 here; reset pulses between edges
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (qout !== 12'h000) begin miscompares++; $display("FAIL async_reset: got %h want 000", qout); end
        @(negedge clk);
        reset = 1'b0; load = 1'b1; load_val = 12'h047;
        @(negedge clk);
        load = 1'b0; enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (qout !== 12'h047) begin miscompares++; $display("FAIL hold[%0d]: got %h want 047", k, qout); end
        end
    endtask

    task test_cout_comb;
        load = 1'b1; load_val = 12'h999;
        @(negedge clk);
        load = 1'b0; enable = 1'b0; up_dn = 1'b1;
        #1;
        vectors++;
        if (cout !== 1'b0) begin miscompares++; $display("FAIL cout_en0: got %b want 0", cout); end
        enable = 1'b1;
        #1;
        vectors++;
        if (cout !== 1'b1) begin miscompares++; $display("FAIL cout_en1: got %b want 1", cout); end
        up_dn = 1'b0;
        #1;
        vectors++;
        if (cout !== 1'b0) begin miscompares++; $display("FAIL cout_dn: got %b want 0", cout); end
        enable = 1'b0;
    endtask

`ifdef COUNT_SATURATE_EN
    task test_saturate;
        load = 1'b1; load_val = 12'h999; up_dn = 1'b1; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (qout !== 12'h999 || cout !== 1'b1) begin miscompares++; $display("FAIL sat_up[%0d]: got %h/%b want 999/1", k, qout, cout); end
        end
        load = 1'b1; load_val = 12'h000; up_dn = 1'b0;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (qout !== 12'h000 || cout !== 1'b1) begin miscompares++; $display("FAIL sat_dn[%0d]: got %h/%b want 000/1", k, qout, cout); end
        end
        enable = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_count_down();
        test_clear_load();
        test_direction_switch();
        test_async_reset_hold();
        test_cout_comb();
`ifdef COUNT_SATURATE_EN
        test_saturate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
